// File: rtl/press_pkg.sv
// Shared types and constants for the press generator and press detector.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } press_gen_state_t;

  localparam int unsigned PRESS_GEN_GAP_DEFAULT = 4;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with an is_one flag for terminal-cycle detection.
module cycle_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         is_one_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/press_generator.sv
// Emits button-style press waveforms (hold, then guaranteed gap) on request.
// Optional multi-press bursts are enabled by defining PRESS_GEN_BURST_EN.
module press_generator
  import press_pkg::*;
#(
  parameter int unsigned HOLD_W     = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYCLES = PRESS_GEN_GAP_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              NC,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HOLD_W-1:0] req_hold,
  input  logic [CNT_W-1:0]  req_count,
  output logic              line,
  output logic              busy,
  output logic              done
);

  press_gen_state_t state_q, state_d;
  logic              pressed_q, pressed_d;
  logic              done_q, done_d;
  logic [HOLD_W-1:0] hold_len_q, hold_len_d;
  logic [HOLD_W-1:0] req_hold_eff;
  logic [HOLD_W-1:0] hold_load_val;
  logic              hold_load, hold_en, hold_is_one;
  logic              gap_load, gap_en, gap_is_one;

  assign req_hold_eff = (req_hold == '0) ? HOLD_W'(1) : req_hold;

`ifdef PRESS_GEN_BURST_EN
  logic [CNT_W-1:0] req_count_eff;
  logic             left_load, left_en, left_is_one;

  assign req_count_eff = (req_count == '0) ? CNT_W'(1) : req_count;

  // left never drops below 1 while busy, so "left > 1" reduces to !is_one
  cycle_down_counter #(.W(CNT_W)) u_left_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (left_load),
    .load_val_i (req_count_eff),
    .en_i       (left_en),
    .is_one_o   (left_is_one)
  );
`else
  logic unused_req_count;
  assign unused_req_count = ^req_count;
`endif

  cycle_down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (hold_load),
    .load_val_i (hold_load_val),
    .en_i       (hold_en),
    .is_one_o   (hold_is_one)
  );

  cycle_down_counter #(.W(HOLD_W)) u_gap_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (gap_load),
    .load_val_i (HOLD_W'(GAP_CYCLES)),
    .en_i       (gap_en),
    .is_one_o   (gap_is_one)
  );

  always_comb begin
    state_d       = state_q;
    hold_len_d    = hold_len_q;
    hold_load     = 1'b0;
    hold_load_val = hold_len_q;
    hold_en       = 1'b0;
    gap_load      = 1'b0;
    gap_en        = 1'b0;
    done_d        = 1'b0;
`ifdef PRESS_GEN_BURST_EN
    left_load     = 1'b0;
    left_en       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d       = HOLD;
          hold_len_d    = req_hold_eff;
          hold_load     = 1'b1;
          hold_load_val = req_hold_eff;
`ifdef PRESS_GEN_BURST_EN
          left_load     = 1'b1;
`endif
        end
      end
      HOLD: begin
        hold_en = 1'b1;
        if (hold_is_one) begin
          state_d  = GAP;
          gap_load = 1'b1;
        end
      end
      GAP: begin
        gap_en = 1'b1;
        if (gap_is_one) begin
`ifdef PRESS_GEN_BURST_EN
          if (!left_is_one) begin
            state_d   = HOLD;
            hold_load = 1'b1;
            left_en   = 1'b1;
          end else
`endif
          begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pressed_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pressed_q  <= 1'b0;
      done_q     <= 1'b0;
      hold_len_q <= '0;
    end else begin
      state_q    <= state_d;
      pressed_q  <= pressed_d;
      done_q     <= done_d;
      hold_len_q <= hold_len_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign line      = pressed_q ^ NC;

endmodule

// File: tb/tb_press_generator.sv
// Randomized and directed bench for press_generator against a per-cycle waveform model.
module tb_press_generator;

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned GAP    = 4;

  localparam int unsigned E_IDLE = 0;
  localparam int unsigned E_HOLD = 1;
  localparam int unsigned E_GAP  = 2;
  localparam int unsigned E_DONE = 3;

  logic              clk;
  logic              resetn;
  logic              NC;
  logic              req_valid;
  logic              req_ready;
  logic [HOLD_W-1:0] req_hold;
  logic [CNT_W-1:0]  req_count;
  logic              line;
  logic              busy;
  logic              done;

  int unsigned total;
  int unsigned bad;
  int unsigned exp_q[$];

  press_generator #(
    .HOLD_W     (HOLD_W),
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .NC        (NC),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_hold  (req_hold),
    .req_count (req_count),
    .line      (line),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: check the current cycle's outputs mid-cycle, then drive the
  // inputs that the next rising edge samples and advance the model.
  task automatic step(input logic v, input logic [HOLD_W-1:0] h,
                      input logic [CNT_W-1:0] c, input logic nc, input logic rn);
    int unsigned cur;
    int unsigned n;
    int unsigned l;
    logic        exp_busy;
    @(negedge clk);
    cur      = (exp_q.size() != 0) ? exp_q.pop_front() : E_IDLE;
    exp_busy = (cur == E_HOLD) || (cur == E_GAP);
    check("busy",  busy,      exp_busy);
    check("ready", req_ready, !exp_busy);
    check("done",  done,      cur == E_DONE);
    check("line",  line,      (cur == E_HOLD) ^ NC);
    req_valid = v;
    req_hold  = h;
    req_count = c;
    NC        = nc;
    resetn    = rn;
    if (!rn) begin
      exp_q.delete();
    end else if (v && !exp_busy) begin
      l = (h == 0) ? 1 : h;
`ifdef PRESS_GEN_BURST_EN
      n = (c == 0) ? 1 : c;
`else
      n = 1;
`endif
      for (int unsigned p = 0; p < n; p++) begin
        for (int unsigned i = 0; i < l; i++) exp_q.push_back(E_HOLD);
        for (int unsigned i = 0; i < GAP; i++) exp_q.push_back(E_GAP);
      end
      exp_q.push_back(E_DONE);
    end
  endtask

  initial begin
    logic              nc_r;
    logic [HOLD_W-1:0] h_r;
    logic [CNT_W-1:0]  c_r;
    total     = 0;
    bad       = 0;
    resetn    = 1'b0;
    NC        = 1'b0;
    req_valid = 1'b0;
    req_hold  = '0;
    req_count = '0;

    repeat (3) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);

    // single press, hold 3
    step(1'b1, 8'd3, 4'd1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);

    // normally-closed line, zero hold and count clamp to one
    step(1'b0, 8'd0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 8'd0, 4'd0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 8'd0, 4'd0, 1'b1, 1'b1);

    // three-press burst (single press without burst support)
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 8'd2, 4'd3, 1'b0, 1'b1);
    repeat (20) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);

    // valid held throughout: back-to-back acceptance in done cycles only
    repeat (40) step(1'b1, 8'd1, 4'd2, 1'b0, 1'b1);
    repeat (12) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);

    // reset in the middle of a hold of a five-press burst
    step(1'b1, 8'd4, 4'd5, 1'b0, 1'b1);
    repeat (2) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 8'd0, 4'd0, 1'b0, 1'b0);
    repeat (30) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);

    // widest hold field, count 7
    step(1'b1, 8'd255, 4'd7, 1'b0, 1'b1);
    repeat (280) step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 8'd0, 4'd0, 1'b0, 1'b0);

    nc_r = 1'b0;
    for (int unsigned t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 49) == 0) nc_r = ~nc_r;
      h_r = ($urandom_range(0, 15) == 0) ? HOLD_W'($urandom_range(0, 40))
                                         : HOLD_W'($urandom_range(0, 6));
      c_r = ($urandom_range(0, 15) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 4));
      step(($urandom_range(0, 2) == 0), h_r, c_r, nc_r,
           ($urandom_range(0, 199) != 0));
    end
    repeat (4) step(1'b0, 8'd0, 4'd0, nc_r, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/press_generator.md
# press_generator

Drives a pushbutton-style line that mimics a human press, for the input side of a press detector (self-test loopback, or driving another board's button input). It accepts press requests over a valid/ready handshake and emits a clean waveform: asserted for a programmed hold time, then released for a guaranteed gap. Output polarity matches normally-open or normally-closed buttons. It sits next to the press detectors in the alarm-clock control path.

## Interface
- `HOLD_W`, 8: width of the hold-time field, in cycles.
- `CNT_W`, 4: width of the press-count field.
- `GAP_CYCLES`, 4: released cycles after every press. Legal range 1..2^HOLD_W-1.

- `clk` in 1: single clock.
- `resetn` in 1: synchronous, active-low reset.
- `NC` in 1: 1 means the line idles high (normally closed). Quasi-static.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the generator can accept a request.
- `req_hold` in HOLD_W: asserted cycles per press. 0 is treated as 1.
- `req_count` in CNT_W: presses in the burst. 0 is treated as 1.
- `line` out 1: button-style output, equal to `pressed ^ NC`.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle pulse when a burst completes.

## Operation
- States (`press_gen_state_t`) and transitions:
  - IDLE → HOLD when `req_valid && req_ready`.
  - HOLD → GAP when `hold_cnt == 1`.
  - GAP → HOLD when `gap_cnt == 1 && left > 1`.
  - GAP → IDLE when `gap_cnt == 1 && left <= 1`.
- `req_ready = (state == IDLE)`.
- On accept:
  - latch `hold_len = max(req_hold, 1)`;
  - load `hold_cnt = hold_len`;
  - load `left = max(req_count, 1)`.
- HOLD:
  - `pressed = 1`; `hold_cnt` decrements each cycle.
  - On exit, load `gap_cnt = GAP_CYCLES`.
- GAP:
  - `pressed = 0`; `gap_cnt` decrements each cycle.
  - On re-entering HOLD: decrement `left` and reload `hold_cnt = hold_len`.
- `done` is registered and is high for the first IDLE cycle after GAP → IDLE.
- Reset values:
  - state IDLE, `pressed = 0`, so `line = NC`;
  - `busy = 0`, `done = 0`, `req_ready = 1`, all counters 0.
- Reset mid-burst: next cycle is IDLE with the line released. No `done` pulse and no partial gap.
- `req_*` is ignored while busy. The generator has no queue, so the requester must hold `req_valid` until it sees ready.
- NC toggled mid-burst: `line` flips polarity combinationally. The state machine is unaffected. NC changes are not supported.

## Timing
- Accept at edge k → `line` pressed in cycles k+1 .. k+hold_len.
- Released for exactly GAP_CYCLES cycles after each press.
- Burst duration: `N*(hold_len+GAP_CYCLES)` cycles.
- On the cycle after the last gap cycle, `done` is 1 and `req_ready` is 1. A request accepted in that same cycle starts immediately (back-to-back, zero bubble).
- `pressed`, state, and `done` are registered. `line` is `pressed` XORed with the `NC` pin, with no extra flop.
- Guarantee for a downstream detector with a two-flop synchronizer: minimum high width 1 cycle, minimum low width GAP_CYCLES. Same-clock consumers see exactly one `press_seen` per press.

## Configuration
- Macro: `PRESS_GEN_BURST_EN`.
- Defined: multi-press bursts behave as described above.
- Undefined:
  - `req_count` is ignored and `left` is treated as 1; each request yields exactly one press.
  - The `left` register and the GAP → HOLD arc are not built.
  - The `req_count` port remains so instantiations do not change.

## Structure
- `press_pkg` holds:
  - the `press_gen_state_t` enum (IDLE, HOLD, GAP; 2 bits);
  - the `PRESS_GEN_GAP_DEFAULT` constant;
  - the state typedef shared with the press detector.
- One sub-module, `cycle_down_counter` (load, enable, width parameter, `is_one` flag). It is instantiated for `hold_cnt` and `gap_cnt`, and for `left` when `PRESS_GEN_BURST_EN` is defined.
- State register: the existing 1-bit register cells or an always_ff with synchronous reset. It must not be a latch.

## Test plan
- Reset, NC=0, then hold=3, count=1 at cycle 10. Expect `line` high in cycles 11-13 and low in 14-17. Expect `done` high in cycle 18 and `req_ready` high in 18.
- NC=1, hold=0, count=0. Expect `line` idles 1, goes low for exactly 1 cycle, then high for 4 cycles, then `done`.
- With `PRESS_GEN_BURST_EN`, hold=2, count=3. Expect three low-high pulses with 4-cycle gaps, total 18 busy cycles, and exactly 3 `press_seen` on a looped-back press detector.
- Raise `req_valid` again in the `done` cycle. Expect the second burst to start on the next cycle with no idle gap. Requests raised while busy are not accepted.
- Assert `resetn=0` mid-HOLD of a 5-press burst. Expect `line` released, state IDLE, and `done` never pulsing for that burst.
- Without the macro, request count=7. Expect exactly one press and `done` after `hold_len+GAP_CYCLES` cycles.
